// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the two-port memory arbiter.
`default_nettype none

package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  typedef struct packed {
    logic        write;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] mask;
  } req_t;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_select.sv
// mem_arbiter_select: combinational 2-way grant selection (round-robin or
// fixed priority with the data port winning).
`default_nettype none

module mem_arbiter_select
  import mem_arbiter_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       grant_valid
);

  always_comb begin
    grant_valid = |req_valid;
    grant       = PORT_FETCH;
    if (req_valid == 2'b11) begin
      grant = ROUND_ROBIN ? ~last_grant : PORT_DATA;
    end else if (req_valid[PORT_DATA]) begin
      grant = PORT_DATA;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch (port 0) and load/store (port 1) requests onto
// a single-port memory, routing each response back to the issuing port.
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_write,
  input  logic [1:0][31:0] req_address,
  input  logic [1:0][31:0] req_wdata,
  input  logic [1:0][31:0] req_mask,
  output logic [1:0]       resp_valid,
  output logic [1:0][31:0] resp_rdata,
  input  logic             memory_ready,
  input  logic             memory_valid,
  input  logic [31:0]      read_memory_data,
  output logic [31:0]      read_memory_address,
  output logic [31:0]      write_memory_address,
  output logic [31:0]      write_memory_data,
  output logic [31:0]      write_memory_mask,
  output logic             memory_command,
  output logic             memory_enable
);

  state_t state;
  req_t   cur;
  logic   owner;
  logic   last_grant;
  logic   grant;
  logic   grant_valid;

  mem_arbiter_select #(
    .ROUND_ROBIN(ROUND_ROBIN)
  ) u_select (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_valid(grant_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cur        <= '0;
      owner      <= PORT_FETCH;
      last_grant <= PORT_FETCH;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            cur.write   <= req_write[grant];
            cur.address <= req_address[grant];
            cur.wdata   <= req_wdata[grant];
            cur.mask    <= req_mask[grant];
            owner       <= grant;
            last_grant  <= grant;
            state       <= ISSUE;
          end
        end
        ISSUE: if (memory_ready) state <= WAIT;
        WAIT:  if (memory_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // reset gates req_ready so nothing is accepted while reset is held
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    resp_rdata = '0;
    if (state == IDLE && reset && grant_valid) begin
      req_ready[grant] = 1'b1;
    end
    if (state == WAIT && memory_valid) begin
      resp_valid[owner] = 1'b1;
      resp_rdata[owner] = cur.write ? 32'h0 : read_memory_data;
    end
  end

  assign memory_enable        = (state == ISSUE) && memory_ready;
  assign memory_command       = cur.write;
  assign read_memory_address  = cur.address;
  assign write_memory_address = cur.address;
  assign write_memory_data    = cur.wdata;
  assign write_memory_mask    = cur.mask;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter (round-robin DUT plus a
// fixed-priority DUT sharing the same stimulus).
`timescale 1ns/1ps

module tb_mem_arbiter;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid, req_write;
  logic [1:0][31:0] req_address, req_wdata, req_mask;
  logic             memory_ready, memory_valid;
  logic [31:0]      read_memory_data;

  logic [1:0]       req_ready, resp_valid;
  logic [1:0][31:0] resp_rdata;
  logic [31:0]      read_memory_address, write_memory_address, write_memory_data, write_memory_mask;
  logic             memory_command, memory_enable;

  logic [1:0]       fp_req_ready, fp_resp_valid;
  logic [1:0][31:0] fp_resp_rdata;
  logic [31:0]      fp_rd_addr, fp_wr_addr, fp_wr_data, fp_wr_mask;
  logic             fp_command, fp_enable;

  logic mem_auto;
  logic inject_valid;

  always #5 clk = ~clk;

  mem_arbiter #(.ROUND_ROBIN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_wdata(req_wdata), .req_mask(req_mask),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .memory_ready(memory_ready), .memory_valid(memory_valid), .read_memory_data(read_memory_data),
    .read_memory_address(read_memory_address), .write_memory_address(write_memory_address),
    .write_memory_data(write_memory_data), .write_memory_mask(write_memory_mask),
    .memory_command(memory_command), .memory_enable(memory_enable)
  );

  mem_arbiter #(.ROUND_ROBIN(1'b0)) dut_fp (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(fp_req_ready), .req_write(req_write),
    .req_address(req_address), .req_wdata(req_wdata), .req_mask(req_mask),
    .resp_valid(fp_resp_valid), .resp_rdata(fp_resp_rdata),
    .memory_ready(memory_ready), .memory_valid(memory_valid), .read_memory_data(read_memory_data),
    .read_memory_address(fp_rd_addr), .write_memory_address(fp_wr_addr),
    .write_memory_data(fp_wr_data), .write_memory_mask(fp_wr_mask),
    .memory_command(fp_command), .memory_enable(fp_enable)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'h5EAD_BEEB;
  endfunction

  typedef struct {
    logic        port;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mask;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  // one-cycle memory: a command seen this cycle completes next cycle
  initial begin : memory_model
    logic        en;
    logic [31:0] a;
    memory_valid     = 1'b0;
    read_memory_data = 32'h0;
    forever begin
      @(negedge clk);
      en = memory_enable & mem_auto;
      a  = read_memory_address;
      @(posedge clk);
      #2;
      memory_valid     = en | inject_valid;
      read_memory_data = mem_f(a);
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    logic p;
    if (!reset) begin
      sb.delete();
    end else begin
      if ((req_valid & req_ready) != 2'b00) begin
        p       = req_ready[1];
        e.port  = p;
        e.write = req_write[p];
        e.addr  = req_address[p];
        e.wdata = req_wdata[p];
        e.mask  = req_mask[p];
        e.rdata = req_write[p] ? 32'h0 : mem_f(req_address[p]);
        sb.push_back(e);
      end
      if (memory_enable) begin
        if (sb.size() == 0) begin
          check_eq("enable_unexpected", {31'd0, memory_enable}, 32'd0);
        end else begin
          check_eq("sb_cmd", {31'd0, memory_command}, {31'd0, sb[0].write});
          check_eq("sb_rd_addr", read_memory_address, sb[0].addr);
          check_eq("sb_wr_addr", write_memory_address, sb[0].addr);
          check_eq("sb_wr_data", write_memory_data, sb[0].wdata);
          check_eq("sb_wr_mask", write_memory_mask, sb[0].mask);
        end
      end
      if (resp_valid != 2'b00) begin
        if (sb.size() == 0) begin
          check_eq("resp_unexpected", {30'd0, resp_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check_eq("sb_resp_port", {30'd0, resp_valid}, e.port ? 32'd2 : 32'd1);
          check_eq("sb_resp_rdata", resp_rdata[e.port], e.rdata);
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (!resp_valid[i]) check_eq("rdata_idle_zero", resp_rdata[i], 32'h0);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int rr_grant[$], rr_cyc[$], fp_grant[$];

  initial begin
    reset        = 1'b0;
    req_valid    = 2'b00;
    req_write    = 2'b00;
    req_address  = '0;
    req_wdata    = '0;
    req_mask     = '0;
    memory_ready = 1'b1;
    mem_auto     = 1'b1;
    inject_valid = 1'b0;
    tick();
    tick();

    // reset state with requests pending
    req_valid      = 2'b11;
    req_address[0] = 32'h8000_0004;
    @(negedge clk);
    check_eq("rst_req_ready", {30'd0, req_ready}, 32'd0);
    check_eq("rst_fp_req_ready", {30'd0, fp_req_ready}, 32'd0);
    check_eq("rst_enable", {31'd0, memory_enable}, 32'd0);
    check_eq("rst_command", {31'd0, memory_command}, 32'd0);
    check_eq("rst_rd_addr", read_memory_address, 32'h0);
    check_eq("rst_wr_data", write_memory_data, 32'h0);
    check_eq("rst_wr_mask", write_memory_mask, 32'h0);
    check_eq("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
    tick();
    req_valid = 2'b00;
    reset     = 1'b1;
    tick();
    tick();

    // single read on port 0
    req_valid      = 2'b01;
    req_write      = 2'b00;
    req_address[0] = 32'h8000_0004;
    req_wdata[0]   = 32'h0BAD_F00D;
    req_mask[0]    = 32'hFFFF_FFFF;
    @(negedge clk);
    check_eq("rd_ready", {30'd0, req_ready}, 32'd1);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    check_eq("rd_enable", {31'd0, memory_enable}, 32'd1);
    check_eq("rd_addr", read_memory_address, 32'h8000_0004);
    check_eq("rd_command", {31'd0, memory_command}, 32'd0);
    tick();
    @(negedge clk);
    check_eq("rd_resp_valid", {30'd0, resp_valid}, 32'd1);
    check_eq("rd_resp_rdata", resp_rdata[0], 32'hDEAD_BEEF);
    tick();

    // single write on port 1
    req_valid      = 2'b10;
    req_write      = 2'b10;
    req_address[1] = 32'h8000_0010;
    req_wdata[1]   = 32'h1234_5678;
    req_mask[1]    = 32'h0000_FFFF;
    @(negedge clk);
    check_eq("wr_ready", {30'd0, req_ready}, 32'd2);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    check_eq("wr_enable", {31'd0, memory_enable}, 32'd1);
    check_eq("wr_command", {31'd0, memory_command}, 32'd1);
    check_eq("wr_addr", write_memory_address, 32'h8000_0010);
    check_eq("wr_data", write_memory_data, 32'h1234_5678);
    check_eq("wr_mask", write_memory_mask, 32'h0000_FFFF);
    tick();
    @(negedge clk);
    check_eq("wr_resp_valid", {30'd0, resp_valid}, 32'd2);
    check_eq("wr_resp_rdata", resp_rdata[1], 32'h0);
    tick();

    // memory_ready low for 4 cycles in ISSUE
    req_valid      = 2'b01;
    req_write      = 2'b00;
    req_address[0] = 32'h8000_0100;
    memory_ready   = 1'b0;
    @(negedge clk);
    check_eq("stall_ready", {30'd0, req_ready}, 32'd1);
    tick();
    req_valid = 2'b00;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("stall_enable_low", {31'd0, memory_enable}, 32'd0);
      check_eq("stall_addr_stable", read_memory_address, 32'h8000_0100);
      check_eq("stall_no_resp", {30'd0, resp_valid}, 32'd0);
      tick();
    end
    memory_ready = 1'b1;
    @(negedge clk);
    check_eq("stall_enable_pulse", {31'd0, memory_enable}, 32'd1);
    tick();
    @(negedge clk);
    check_eq("stall_enable_once", {31'd0, memory_enable}, 32'd0);
    check_eq("stall_resp_valid", {30'd0, resp_valid}, 32'd1);
    check_eq("stall_resp_rdata", resp_rdata[0], mem_f(32'h8000_0100));
    tick();

    // reset while in WAIT, then a late memory_valid
    req_valid      = 2'b10;
    req_write      = 2'b00;
    req_address[1] = 32'h8000_0200;
    mem_auto       = 1'b0;
    @(negedge clk);
    check_eq("rstw_ready", {30'd0, req_ready}, 32'd2);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    check_eq("rstw_enable", {31'd0, memory_enable}, 32'd1);
    tick();
    @(negedge clk);
    check_eq("rstw_wait_no_resp", {30'd0, resp_valid}, 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_eq("rstw_addr_cleared", read_memory_address, 32'h0);
    check_eq("rstw_in_reset_no_resp", {30'd0, resp_valid}, 32'd0);
    tick();
    reset    = 1'b1;
    mem_auto = 1'b1;
    tick();
    inject_valid = 1'b1;
    @(negedge clk);
    check_eq("rstw_late_valid_seen", {31'd0, memory_valid}, 32'd1);
    check_eq("rstw_late_no_resp", {30'd0, resp_valid}, 32'd0);
    check_eq("rstw_late_no_resp_fp", {30'd0, fp_resp_valid}, 32'd0);
    tick();
    inject_valid   = 1'b0;
    req_valid      = 2'b01;
    req_address[0] = 32'h8000_0300;
    @(negedge clk);
    check_eq("post_rst_ready", {30'd0, req_ready}, 32'd1);
    tick();
    req_valid = 2'b00;
    tick();
    @(negedge clk);
    check_eq("post_rst_resp", {30'd0, resp_valid}, 32'd1);
    check_eq("post_rst_rdata", resp_rdata[0], mem_f(32'h8000_0300));
    tick();

    // contention: both ports continuously, last_grant freshly reset to 0
    reset = 1'b0;
    tick();
    reset          = 1'b1;
    tick();
    req_valid      = 2'b11;
    req_write      = 2'b10;
    req_address[0] = 32'h8000_1000;
    req_address[1] = 32'h8000_2000;
    req_wdata[1]   = 32'hCAFE_F00D;
    req_mask[1]    = 32'hFF00_FF00;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        rr_grant.push_back(int'(req_ready[1]));
        rr_cyc.push_back(c);
      end
      if (fp_req_ready != 2'b00) fp_grant.push_back(int'(fp_req_ready[1]));
      tick();
    end
    req_valid = 2'b00;
    check_eq("rr_grant_count", rr_grant.size(), 32'd4);
    check_eq("fp_grant_count", fp_grant.size(), 32'd4);
    for (int i = 0; i < rr_grant.size() && i < 4; i++) begin
      check_eq("rr_grant_port", rr_grant[i], (i % 2 == 0) ? 32'd1 : 32'd0);
      check_eq("rr_grant_cycle", rr_cyc[i], 32'(3 * i));
    end
    for (int i = 0; i < fp_grant.size(); i++) begin
      check_eq("fp_grant_port", fp_grant[i], 32'd1);
    end

    tick();
    tick();
    tick();
    check_eq("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port simulation memory between an instruction-fetch requester (port 0) and a load/store requester (port 1). Sits between the requesters and the memory model's enable/command interface, serialises accesses one at a time, and returns each response only to the port that issued it.

## Interface
Parameters:
- ROUND_ROBIN, 1, 1 = alternate grant on contention; 0 = fixed priority, port 1 wins.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid[p]  in  1 each (p=0,1)  requester p presents a request.
- req_ready[p]  out  1 each  arbiter accepts p's request this cycle.
- req_write[p]  in  1 each  1 = write, 0 = read.
- req_address[p]  in  32 each  byte address, forwarded unmodified.
- req_wdata[p]  in  32 each  write data.
- req_mask[p]  in  32 each  per-bit write mask.
- resp_valid[p]  out  1 each  response for p's accepted request.
- resp_rdata[p]  out  32 each  read data; 0 when resp_valid[p]=0.
- memory_ready  in  1  memory can take a command.
- memory_valid  in  1  memory completed the previous command.
- read_memory_data  in  32  memory read data.
- read_memory_address, write_memory_address  out  32  both driven from the latched address.
- write_memory_data, write_memory_mask  out  32  latched data/mask.
- memory_command  out  1  latched req_write.
- memory_enable  out  1  one-cycle command strobe.

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: req_ready[p] = (selected port == p); selection computed combinationally from req_valid and last_grant. On handshake latch write/address/data/mask and owner, go ISSUE. No request: stay.
- Selection: one valid -> that port. Both valid, ROUND_ROBIN=1 -> port != last_grant; ROUND_ROBIN=0 -> port 1. last_grant updates on each handshake.
- ISSUE: memory_enable = memory_ready. If memory_ready go WAIT, else hold (fields stable).
- WAIT: on memory_valid assert resp_valid[owner] same cycle, resp_rdata[owner] = read_memory_data for reads, 0 for writes; go IDLE. Otherwise stay.
- memory_valid outside WAIT is ignored.
- req_ready is 0 in ISSUE and WAIT; at most one transaction outstanding.
- Writes also produce resp_valid (acknowledge).

## Timing
- Reset (asserted): state IDLE, last_grant = 0, latched fields 0, memory_enable 0, memory_command 0, all resp_valid 0, all memory address/data/mask outputs 0. req_ready may be combinationally 1 in IDLE only after reset deasserts.
- Reset mid-transaction: transaction discarded, no resp_valid; a late memory_valid after release is ignored (state IDLE).
- Latency with memory_ready=1 and 1-cycle memory: handshake cycle N, memory_enable cycle N+1, memory_valid and resp_valid cycle N+2, next handshake possible N+3. Throughput one access per 3 cycles.
- memory_ready low for k cycles in ISSUE adds k cycles.
- Request that is not accepted must be held stable by requester; arbiter may switch selection while requester's valid stays high only between cycles with no handshake.

## Structure
- Package mem_arbiter_pkg: state enum (IDLE, ISSUE, WAIT), port index constants PORT_FETCH=0, PORT_DATA=1, request struct (write, address, wdata, mask).
- Sub-module mem_arbiter_select: combinational 2-way selector taking req_valid, last_grant, ROUND_ROBIN; outputs grant index and grant_valid.

## Test plan
- Single read port 0, addr 0x80000004, memory returns 0xDEADBEEF -> memory_enable cycle N+1 with read address 0x80000004, command 0; resp_valid[0] and resp_rdata[0]=0xDEADBEEF at N+2; resp_valid[1]=0.
- Write port 1, addr 0x80000010, data 0x12345678, mask 0x0000FFFF -> memory_command 1, write outputs match at N+1; resp_valid[1] at N+2, resp_rdata[1]=0.
- Both ports request continuously, ROUND_ROBIN=1 -> grants 1,0,1,0 (last_grant reset 0), one every 3 cycles; ROUND_ROBIN=0 -> port 1 every grant.
- memory_ready held 0 for 4 cycles in ISSUE -> memory_enable stays 0, fields stable, enable pulses once when ready rises; resp 2 cycles after ISSUE entry + 4... i.e. N+6.
- Reset asserted in WAIT, memory_valid pulses next cycle after release -> no resp_valid, state IDLE, next request serviced normally.
